// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The FSM encoding is fixed so the state can be decoded from debug taps.
package pipeline_hazard_controller_pkg;

  localparam int unsigned RegIdxW     = 4;
  localparam int unsigned DefaultCntW = 16;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFlush   = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with async active-low reset and a synchronous clear.
// The clear input takes priority over the increment input.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
    end else if (clr) begin
      value_q <= '0;
    end else if (inc && (value_q != {W{1'b1}})) begin
      value_q <= value_q + 1'b1;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: data hazards, taken branches
// and SRAM waits, with saturating performance counters and a wait watchdog.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned CNT_W   = DefaultCntW,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               forwarding_en,
  input  logic               with_src1,
  input  logic               with_src2,
  input  logic [RegIdxW-1:0] Reg_src1,
  input  logic [RegIdxW-1:0] Reg_src2,
  input  logic [RegIdxW-1:0] EXE_Dest,
  input  logic               EXE_WB_EN,
  input  logic               EXE_MEM_R_EN,
  input  logic [RegIdxW-1:0] MEM_Dest,
  input  logic               MEM_WB_EN,
  input  logic               branch_taken,
  input  logic               mem_req,
  input  logic               mem_ready,
  output logic               Freeze,
  output logic               bubble,
  output logic               flush,
  output logic               hold_all,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [CNT_W-1:0]   memwait_cnt,
  output logic               mem_timeout
);

  localparam int unsigned WaitW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  hz_state_e        state_q, state_d;
  logic             hit_src1, hit_src2, hazard, mem_stall;
  logic             freeze_c, bubble_c, flush_c, hold_c;
  logic             stall_inc, flush_inc, memwait_inc;
  logic             wait_inc, wait_clr, tmo_set;
  logic [WaitW-1:0] wait_value;
  logic             mem_timeout_q;

  // With forwarding only a load in EX can't be bypassed; without it every
  // pending write in EX or MEM blocks the read.
  assign hit_src1 = with_src1 &
      ((EXE_WB_EN & (Reg_src1 == EXE_Dest) & (~forwarding_en | EXE_MEM_R_EN)) |
       (MEM_WB_EN & (Reg_src1 == MEM_Dest) & ~forwarding_en));
  assign hit_src2 = with_src2 &
      ((EXE_WB_EN & (Reg_src2 == EXE_Dest) & (~forwarding_en | EXE_MEM_R_EN)) |
       (MEM_WB_EN & (Reg_src2 == MEM_Dest) & ~forwarding_en));
  assign hazard    = hit_src1 | hit_src2;
  assign mem_stall = mem_req & ~mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d = StMemWait;
        end else if (branch_taken) begin
          state_d = StFlush;
        end
      end
      StMemWait: if (mem_ready) state_d = StRun;
      StFlush:   state_d = mem_stall ? StMemWait : StRun;
      default:   state_d = StRun;
    endcase
  end

  always_comb begin
    freeze_c    = 1'b0;
    bubble_c    = 1'b0;
    flush_c     = 1'b0;
    hold_c      = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    memwait_inc = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          hold_c   = 1'b1;
          freeze_c = 1'b1;
        end else if (branch_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (hazard) begin
          freeze_c  = 1'b1;
          bubble_c  = 1'b1;
          stall_inc = 1'b1;
        end
      end
      StMemWait: begin
        hold_c      = 1'b1;
        freeze_c    = 1'b1;
        memwait_inc = 1'b1;
      end
      StFlush: begin
        flush_c   = 1'b1;
        bubble_c  = 1'b1;
        flush_inc = 1'b1;
        hold_c    = mem_stall;
      end
      default: ;
    endcase
  end

  // Outputs are forced quiet while reset is asserted, independent of inputs.
  assign Freeze   = rst & freeze_c;
  assign bubble   = rst & bubble_c;
  assign flush    = rst & flush_c;
  assign hold_all = rst & hold_c;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .clr   (1'b0),
    .value (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .clr   (1'b0),
    .value (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_memwait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (memwait_inc),
    .clr   (1'b0),
    .value (memwait_cnt)
  );

  assign wait_inc = (state_q == StMemWait) & ~mem_ready;
  assign wait_clr = (state_q != StMemWait) | mem_ready;

  sat_counter #(.W(WaitW)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wait_inc),
    .clr   (wait_clr),
    .value (wait_value)
  );

  // Fires on the edge where the wait count becomes TIMEOUT.
  assign tmo_set = (TIMEOUT != 0) && wait_inc && ((32'(wait_value) + 32'd1) >= TIMEOUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_timeout_q <= 1'b0;
    end else if (tmo_set) begin
      mem_timeout_q <= 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: combinational vector table, directed corner sequences
// and randomized traffic against a cycle-level behavioural model.
`timescale 1ns/100ps
module tb_pipeline_hazard_controller;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;
  always #5 clk = clk_en ? ~clk : 1'b0;

  logic       forwarding_en, with_src1, with_src2, EXE_WB_EN, EXE_MEM_R_EN, MEM_WB_EN;
  logic       branch_taken, mem_req, mem_ready;
  logic [3:0] Reg_src1, Reg_src2, EXE_Dest, MEM_Dest;

  logic        Freeze, bubble, flush, hold_all, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt, memwait_cnt;
  logic        Freeze_b, bubble_b, flush_b, hold_all_b, mem_timeout_b;
  logic [1:0]  stall_cnt_b, flush_cnt_b, memwait_cnt_b;

  pipeline_hazard_controller #(.CNT_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .forwarding_en(forwarding_en),
    .with_src1(with_src1), .with_src2(with_src2),
    .Reg_src1(Reg_src1), .Reg_src2(Reg_src2),
    .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN),
    .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .Freeze(Freeze), .bubble(bubble), .flush(flush), .hold_all(hold_all),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt),
    .mem_timeout(mem_timeout)
  );

  // Narrow counters and watchdog disabled, fed the same stimulus.
  pipeline_hazard_controller #(.CNT_W(2), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .forwarding_en(forwarding_en),
    .with_src1(with_src1), .with_src2(with_src2),
    .Reg_src1(Reg_src1), .Reg_src2(Reg_src2),
    .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN),
    .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .Freeze(Freeze_b), .bubble(bubble_b), .flush(flush_b), .hold_all(hold_all_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b), .memwait_cnt(memwait_cnt_b),
    .mem_timeout(mem_timeout_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: is the pipeline waiting on memory, is a flush cycle pending.
  bit m_wait, m_flushing, m_tmo;
  int m_waited, m_stall, m_flush, m_memwait;

  typedef struct {
    logic fwd; logic w1; logic [3:0] s1; logic w2; logic [3:0] s2;
    logic [3:0] ed; logic ewb; logic er; logic [3:0] md; logic mwb;
    logic br; logic mreq; logic mrdy;
    logic ef; logic eb; logic efl; logic eh;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit src_hit(logic v, logic [3:0] s);
    return v && ((EXE_WB_EN && s == EXE_Dest && (!forwarding_en || EXE_MEM_R_EN)) ||
                 (MEM_WB_EN && s == MEM_Dest && !forwarding_en));
  endfunction

  function automatic bit hazard();
    return src_hit(with_src1, Reg_src1) || src_hit(with_src2, Reg_src2);
  endfunction

  function automatic int sat(int x, int mx);
    return (x > mx) ? mx : x;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_flushing = 0; m_tmo = 0;
    m_waited = 0; m_stall = 0; m_flush = 0; m_memwait = 0;
  endtask

  task automatic expect_out(output bit ef, output bit eb, output bit efl, output bit eh);
    bit ms;
    ms = mem_req && !mem_ready;
    ef = 0; eb = 0; efl = 0; eh = 0;
    if (m_wait) begin
      ef = 1; eh = 1;
    end else if (m_flushing) begin
      efl = 1; eb = 1; eh = ms;
    end else if (ms) begin
      ef = 1; eh = 1;
    end else if (branch_taken) begin
      efl = 1; eb = 1;
    end else if (hazard()) begin
      ef = 1; eb = 1;
    end
  endtask

  task automatic model_step();
    bit ms;
    ms = mem_req && !mem_ready;
    if (m_wait) begin
      m_memwait++;
      if (mem_ready) begin
        m_wait = 0; m_waited = 0;
      end else begin
        m_waited++;
        if (m_waited >= TMO) m_tmo = 1;
      end
    end else if (m_flushing) begin
      m_flush++; m_flushing = 0; m_wait = ms;
    end else if (ms) begin
      m_wait = 1;
    end else if (branch_taken) begin
      m_flushing = 1;
    end else if (hazard()) begin
      m_stall++;
    end
  endtask

  task automatic check_all(string tag);
    bit ef, eb, efl, eh;
    expect_out(ef, eb, efl, eh);
    chk({tag, ".Freeze"}, Freeze, ef);
    chk({tag, ".bubble"}, bubble, eb);
    chk({tag, ".flush"}, flush, efl);
    chk({tag, ".hold_all"}, hold_all, eh);
    chk({tag, ".stall_cnt"}, stall_cnt, sat(m_stall, 65535));
    chk({tag, ".flush_cnt"}, flush_cnt, sat(m_flush, 65535));
    chk({tag, ".memwait_cnt"}, memwait_cnt, sat(m_memwait, 65535));
    chk({tag, ".mem_timeout"}, mem_timeout, m_tmo);
    chk({tag, ".stall_cnt_b"}, stall_cnt_b, sat(m_stall, 3));
    chk({tag, ".flush_cnt_b"}, flush_cnt_b, sat(m_flush, 3));
    chk({tag, ".memwait_cnt_b"}, memwait_cnt_b, sat(m_memwait, 3));
    chk({tag, ".mem_timeout_b"}, mem_timeout_b, 0);
  endtask

  // One clock: check at the falling edge, advance the model on the rising one.
  task automatic cyc(string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    forwarding_en = 1; with_src1 = 0; with_src2 = 0; Reg_src1 = 0; Reg_src2 = 0;
    EXE_Dest = 0; EXE_WB_EN = 0; EXE_MEM_R_EN = 0; MEM_Dest = 0; MEM_WB_EN = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic apply(vec_t v);
    forwarding_en = v.fwd; with_src1 = v.w1; Reg_src1 = v.s1; with_src2 = v.w2;
    Reg_src2 = v.s2; EXE_Dest = v.ed; EXE_WB_EN = v.ewb; EXE_MEM_R_EN = v.er;
    MEM_Dest = v.md; MEM_WB_EN = v.mwb; branch_taken = v.br; mem_req = v.mreq;
    mem_ready = v.mrdy;
  endtask

  task automatic set_load_use();
    set_idle();
    with_src1 = 1; Reg_src1 = 3; EXE_Dest = 3; EXE_WB_EN = 1; EXE_MEM_R_EN = 1;
  endtask

  initial begin
    //            fwd w1 s1 w2 s2  ed  ewb er md mwb br mreq mrdy  F  B fl  H
    tbl[0]  = '{1, 1, 3, 0, 0,  3,  1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0};
    tbl[1]  = '{1, 1, 3, 0, 0,  3,  1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0};
    tbl[2]  = '{0, 1, 3, 0, 0,  5,  0, 0, 3, 1, 0, 0, 0,  1, 1, 0, 0};
    tbl[3]  = '{1, 1, 3, 0, 0,  5,  0, 0, 3, 1, 0, 0, 0,  0, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 1, 15, 15, 1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 15, 15, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0};
    tbl[6]  = '{1, 1, 3, 0, 0,  3,  1, 1, 0, 0, 1, 0, 0,  0, 1, 1, 0};
    tbl[7]  = '{1, 0, 0, 0, 0,  0,  0, 0, 0, 0, 1, 1, 0,  1, 0, 0, 1};
    tbl[8]  = '{1, 1, 3, 0, 0,  3,  1, 1, 0, 0, 0, 1, 1,  1, 1, 0, 0};
    tbl[9]  = '{0, 1, 7, 0, 0,  7,  1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0};
    tbl[10] = '{0, 1, 7, 0, 0,  7,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0};

    // Reset held with a memory stall on the inputs: outputs must stay quiet.
    apply(tbl[7]);
    #1;
    chk("rst.hold_all", hold_all, 0);
    chk("rst.Freeze", Freeze, 0);
    chk("rst.stall_cnt", stall_cnt, 0);
    chk("rst.mem_timeout", mem_timeout, 0);
    rst = 1'b1;

    // Clock is parked, so every vector sees the RUN state.
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i]);
      #1;
      chk($sformatf("tbl%0d.Freeze", i), Freeze, tbl[i].ef);
      chk($sformatf("tbl%0d.bubble", i), bubble, tbl[i].eb);
      chk($sformatf("tbl%0d.flush", i), flush, tbl[i].efl);
      chk($sformatf("tbl%0d.hold_all", i), hold_all, tbl[i].eh);
    end

    set_idle();
    model_reset();
    clk_en = 1'b1;
    @(posedge clk);
    #1;

    // Load-use stall for one cycle.
    set_load_use();
    cyc("lu");
    set_idle();
    cyc("lu_idle");
    chk("lu.stall_cnt", stall_cnt, 1);

    // Branch together with a hazard: two flush cycles, no stall counted.
    set_load_use();
    branch_taken = 1;
    cyc("br_run");
    branch_taken = 0;
    cyc("br_flush");
    set_idle();
    cyc("br_idle");
    chk("br.flush_cnt", flush_cnt, 1);
    chk("br.stall_cnt", stall_cnt, 1);

    // Four waiting cycles then ready.
    mem_req = 1;
    for (int i = 0; i < 4; i++) cyc("mw");
    mem_ready = 1;
    cyc("mw_ready");
    set_idle();
    cyc("mw_ret");
    chk("mw.memwait_cnt", memwait_cnt, 4);
    chk("mw.ret_hold_all", hold_all, 0);

    // Watchdog: 1 RUN cycle + 8 MEM_WAIT cycles before mem_timeout sets.
    mem_req = 1;
    for (int i = 1; i <= 10; i++) begin
      cyc("tmo");
      if (i == 8) chk("tmo.before", mem_timeout, 0);
      if (i == 9) chk("tmo.rise", mem_timeout, 1);
    end
    chk("tmo.sticky", mem_timeout, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid.hold_all", hold_all, 0);
    chk("rst_mid.Freeze", Freeze, 0);
    chk("rst_mid.mem_timeout", mem_timeout, 0);
    chk("rst_mid.memwait_cnt", memwait_cnt, 0);
    set_idle();
    model_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc("post_rst");

    // Saturation of the 2-bit counter.
    set_load_use();
    for (int i = 0; i < 5; i++) cyc("sat");
    set_idle();
    cyc("sat_idle");
    chk("sat.stall_cnt_b", stall_cnt_b, 3);
    chk("sat.stall_cnt", stall_cnt, 5);

    // Randomized traffic with narrow register indices to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      forwarding_en = ($urandom_range(0, 3) != 0);
      with_src1 = $urandom_range(0, 1);
      with_src2 = $urandom_range(0, 1);
      Reg_src1 = 4'($urandom_range(0, 3));
      Reg_src2 = 4'($urandom_range(0, 3));
      EXE_Dest = 4'($urandom_range(0, 3));
      MEM_Dest = 4'($urandom_range(0, 3));
      EXE_WB_EN = $urandom_range(0, 1);
      EXE_MEM_R_EN = $urandom_range(0, 1);
      MEM_WB_EN = $urandom_range(0, 1);
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_req = ($urandom_range(0, 5) == 0);
      mem_ready = ($urandom_range(0, 9) < 3);
      cyc("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
